// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg: shared FSM states, mode encodings and select-width helper for chan_scan_mux
package chan_scan_pkg;
  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int selw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chan_scan_sel.sv
// chan_scan_sel: combinational NCH:1 W-bit selector; selects beyond NCH-1 yield zero
module chan_scan_sel #(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int SELW = 2
) (
  input  logic [NCH*W-1:0] in_data,
  input  logic [SELW-1:0]  sel,
  output logic [W-1:0]     data
);
  always_comb begin
    data = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SELW'(k)) data = in_data[k*W +: W];
  end
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered NCH:1 mux with direct capture and dwell-timed auto-scan on a valid/ready port
// Optional channel masking for the sweep is built when CHAN_SCAN_MUX_MASK_EN is defined.
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int DWELL_W = 4,
  localparam int SELW = selw(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
`ifdef CHAN_SCAN_MUX_MASK_EN
  input  logic [NCH-1:0]     ch_mask,
`endif
  output logic [W-1:0]       out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  state_t state;
  logic [SELW-1:0] ch, csel, first, nxt;
  logic [DWELL_W-1:0] dcnt, dwell_q;
  logic [NCH-1:0] mvec, mask_q;
  logic [W-1:0] sdata;
  logic has_first, has_nxt, cap_ok, at_end, dcap, scap, go;
`ifdef CHAN_SCAN_MUX_MASK_EN
  assign mvec = ch_mask;
`else
  assign mvec = '1;
`endif
  chan_scan_sel #(.NCH(NCH), .W(W), .SELW(SELW)) u_sel (
    .in_data(in_data),
    .sel(csel),
    .data(sdata)
  );
  // descending scan so the lowest qualifying channel wins
  always_comb begin
    first = '0;
    has_first = 1'b0;
    nxt = '0;
    has_nxt = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mvec[k]) begin
        first = SELW'(k);
        has_first = 1'b1;
      end
      if (mask_q[k] && SELW'(k) > ch) begin
        nxt = SELW'(k);
        has_nxt = 1'b1;
      end
    end
  end
  assign busy = state != IDLE;
  assign csel = busy ? ch : sel;
  assign cap_ok = !out_valid || out_ready;
  assign at_end = dcnt == dwell_q;
  assign dcap = state == IDLE && start && mode == MODE_DIRECT && cap_ok;
  assign go = state == IDLE && start && mode == MODE_SCAN && has_first;
  assign scap = cap_ok && (state == HOLD || (state == DWELL && at_end));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      dcnt <= '0;
      dwell_q <= '0;
      mask_q <= '0;
      out_data <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (dcap || scap) begin
        out_data <= sdata;
        out_ch <= csel;
        out_valid <= 1'b1;
      end
      if (scap) begin
        ch <= nxt;
        dcnt <= '0;
        state <= has_nxt ? DWELL : IDLE;
      end else if (state == DWELL) begin
        if (at_end) state <= HOLD;
        else dcnt <= dcnt + 1'b1;
      end else if (go) begin
        dwell_q <= dwell;
        mask_q <= mvec;
        ch <= first;
        dcnt <= '0;
        state <= DWELL;
      end
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: randomized scoreboard bench for chan_scan_mux against a sweep-level model
module tb_chan_scan_mux;
  localparam int NCH = 4, W = 8, DW = 4, SW = 2;
  logic clk = 0, rst_n = 0, mode = 0, start = 0, out_ready = 1;
  logic out_valid, busy;
  logic [NCH*W-1:0] in_data = '0;
  logic [SW-1:0] sel = '0, out_ch;
  logic [DW-1:0] dwell = '0;
  logic [NCH-1:0] mask = '1;
  logic [W-1:0] out_data;
  typedef struct {logic [W-1:0] d; logic [SW-1:0] ch; int cyc;} exp_t;
  exp_t q[$];
  int nchk = 0, nbad = 0, cyc = 0, c0;
  bit rnd = 0;

  chan_scan_mux #(.NCH(NCH), .W(W), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode),
    .dwell(dwell), .start(start),
`ifdef CHAN_SCAN_MUX_MASK_EN
    .ch_mask(mask),
`endif
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] chv(input int k);
    return in_data[k*W +: W];
  endfunction

  task automatic push(input logic [W-1:0] d, input int k, input int t);
    exp_t e;
    e.d = d;
    e.ch = SW'(k);
    e.cyc = t;
    q.push_back(e);
  endtask

  // a sweep emits each enabled channel in ascending order, dwell+1 cycles apart
  task automatic push_scan(input int d, input logic [NCH-1:0] m, input bit timed, input int s);
    int i = 0;
    for (int k = 0; k < NCH; k++)
      if (m[k]) begin
        i++;
        push(chv(k), k, timed ? s + 1 + (d + 1) * i : -1);
      end
  endtask

  task automatic direct(input int s, input bit timed);
    tick();
    mode = 0;
    sel = SW'(s);
    start = 1;
    out_ready = 1;
    push(chv(s), s, timed ? cyc + 1 : -1);
    tick();
    start = 0;
  endtask

  task automatic scan(input int d, input logic [NCH-1:0] m, input bit timed, output int s);
`ifndef CHAN_SCAN_MUX_MASK_EN
    m = '1;
`endif
    tick();
    s = cyc;
    mode = 1;
    dwell = DW'(d);
    mask = m;
    start = 1;
    push_scan(d, m, timed, s);
    tick();
    start = 0;
    if (m == '0) chk("mask0_busy", busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0 || out_valid) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 400, 1);
  endtask

  initial begin
    exp_t e;
    logic hv = 0;
    logic [W-1:0] hd;
    logic [SW-1:0] hc;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) hv = 0;
      else begin
        if (hv) begin
          chk("stable_data", out_data, hd);
          chk("stable_ch", out_ch, hc);
          chk("stable_valid", out_valid, 1);
        end
        hv = out_valid && !out_ready;
        hd = out_data;
        hc = out_ch;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            nchk++;
            nbad++;
            $display("FAIL unexpected_sample: got ch %0d data %0h, want none (cycle %0d)", out_ch, out_data, cyc);
          end else begin
            e = q.pop_front();
            chk("data", out_data, e.d);
            chk("ch", out_ch, e.ch);
            if (e.cyc >= 0) chk("time", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    rst_n = 1;
    in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    direct(3, 1);
    direct(0, 1);
    direct(2, 1);
    wait_idle();
    scan(2, '1, 1, c0);
    chk("scan_busy", busy, 1);
    wait_idle();
    chk("scan_done_busy", busy, 0);
    scan(2, '1, 1, c0);
    q[0].cyc = c0 + 9;
    q[1].cyc = c0 + 10;
    q[2].cyc = c0 + 13;
    q[3].cyc = c0 + 16;
    while (cyc < c0 + 4) tick();
    out_ready = 0;
    repeat (5) begin
      chk("stall_busy", busy, 1);
      chk("stall_data", out_data, 8'hAA);
      tick();
    end
    out_ready = 1;
    wait_idle();
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    scan(0, '1, 1, c0);
    while (cyc < c0 + 5) begin
      start = 1;
      mode = 1'($urandom_range(0, 1));
      sel = SW'($urandom_range(0, NCH - 1));
      tick();
    end
    start = 0;
    wait_idle();
    tick();
    c0 = cyc;
    out_ready = 0;
    mode = 0;
    sel = 1;
    start = 1;
    push(chv(1), 1, c0 + 2);
    tick();
    sel = 2;
    tick();
    start = 0;
    out_ready = 1;
    wait_idle();
`ifdef CHAN_SCAN_MUX_MASK_EN
    scan(0, 4'b1010, 1, c0);
    wait_idle();
    scan(1, 4'b0000, 1, c0);
    repeat (4) begin
      chk("mask0_idle", busy, 0);
      tick();
    end
`endif
    in_data = {8'h9A, 8'h78, 8'h56, 8'h34};
    scan(2, '1, 1, c0);
    while (cyc < c0 + 8) tick();
    chk("rst_q_left", q.size(), 2);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ch", out_ch, 0);
    q.delete();
    repeat (2) tick();
    rst_n = 1;
    repeat (12) tick();
    chk("post_rst_valid", out_valid, 0);
    rnd = 1;
    repeat (40) begin
      tick();
      in_data = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) direct($urandom_range(0, NCH - 1), 0);
      else scan($urandom_range(0, 3), NCH'($urandom_range(0, 15)), 0, c0);
      wait_idle();
    end
    rnd = 0;
    out_ready = 1;
    wait_idle();
    chk("q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
